// File: rtl/ahb_bridge_pkg.sv
// Shared types, encodings and helpers for the AHB-to-APB bridge front end.
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'd0,
    HTRANS_BUSY = 2'd1,
    HTRANS_NSEQ = 2'd2,
    HTRANS_SEQ  = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Beat counter holds length-1 of the longest fixed burst (16 beats).
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_DATA = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_DONE = 3'd4,
    ST_ERR1    = 3'd5,
    ST_ERR2    = 3'd6
  } state_e;

  // Command entry layout, MSB first: {hwrite, hburst[2:0], hsize[2:0], haddr}.
  function automatic int unsigned cmd_width(input int unsigned addr_w);
    return addr_w + 32'd7;
  endfunction

  // Beats in a fixed-length burst; 0 for SINGLE and undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bridge_frontend_if.sv
// AHB-Lite slave-side bus bundle for the bridge front end.
interface ahb_bridge_frontend_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) ();
  logic                  hsel;
  logic                  hready_in;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready_o;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, hready_in, htrans, hwrite, haddr, hburst, hsize, hwdata,
    input  hready_o, hresp, hrdata
  );

  modport slave (
    input  hsel, hready_in, htrans, hwrite, haddr, hburst, hsize, hwdata,
    output hready_o, hresp, hrdata
  );
endinterface

// File: rtl/ahb_burst_tracker.sv
// Tracks remaining beats of the current AHB burst and flags protocol violations.
module ahb_burst_tracker
  import ahb_bridge_pkg::*;
(
  input  logic       hclk,
  input  logic       resetn,
  input  logic       track_i,   // sampled NSEQ/SEQ transfer
  input  logic [1:0] htrans_i,
  input  logic [2:0] hburst_i,
  output logic       prot_err_o
);

  logic [2:0]        burst_q;
  logic [BEAT_W-1:0] beat_q;
  logic              err_q;
  logic [4:0]        len_c;
  logic              fixed_c;

  assign len_c   = burst_len(hburst_i);
  assign fixed_c = (burst_len(burst_q) != 5'd0);

  // Load on NSEQ, count down on SEQ of a fixed burst; sticky error until reset.
  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      burst_q <= HBURST_SINGLE;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else if (track_i) begin
      if (htrans_i == HTRANS_NSEQ) begin
        burst_q <= hburst_i;
        beat_q  <= (len_c == 5'd0) ? '0 : BEAT_W'(len_c - 5'd1);
        if (beat_q != '0) err_q <= 1'b1;
      end else if (burst_q == HBURST_SINGLE) begin
        err_q <= 1'b1;
      end else if (fixed_c) begin
        if (beat_q == '0) err_q <= 1'b1;
        else              beat_q <= beat_q - BEAT_W'(1);
      end
    end
  end

  assign prot_err_o = err_q;

endmodule

// File: rtl/ahb_bridge_frontend.sv
// AHB-Lite slave front end: decodes transfers into command/write-data FIFO
// pushes and returns read data (with APB error status) from the read FIFO.
module ahb_bridge_frontend
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(32'h0001_0000)
) (
  input  logic                               hclk,
  input  logic                               resetn,
  ahb_bridge_frontend_if.slave               ahb,
  output logic                               cmd_wen,
  output logic [cmd_width(ADDR_WIDTH)-1:0]   cmd_wdata,
  input  logic                               cmd_full,
  output logic                               wd_wen,
  output logic [DATA_WIDTH-1:0]              wd_wdata,
  input  logic                               wd_full,
  output logic                               rd_ren,
  input  logic [DATA_WIDTH:0]                rd_rdata,
  input  logic                               rd_empty,
  output logic                               prot_err
);

  localparam int unsigned CMD_W    = cmd_width(ADDR_WIDTH);
  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  state_e                state_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic                  hready_c, hresp_c, cmd_wen_c, wd_wen_c, rd_ren_c;
  logic                  sample_c, active_c, legal_c;
  logic                  in_range_c, size_ok_c, aligned_c;
  logic [ADDR_WIDTH-1:0] offset_c;
  logic [7:0]            align_mask_c;

  // Address-phase qualification and legality decode.
  assign sample_c     = ahb.hsel & ahb.hready_in & hready_c;
  assign active_c     = ahb.htrans[1];
  assign offset_c     = ahb.haddr - BASE_ADDR;
  assign in_range_c   = (ahb.haddr >= BASE_ADDR) && (offset_c < ADDR_SPAN);
  assign size_ok_c    = (ahb.hsize <= 3'(MAX_SIZE));
  assign align_mask_c = ~(8'hFF << ahb.hsize);
  assign aligned_c    = ((ahb.haddr[7:0] & align_mask_c) == 8'd0);
  assign legal_c      = in_range_c & size_ok_c & aligned_c;

  // Per-state bus response and FIFO strobes.
  always_comb begin
    hready_c  = 1'b1;
    hresp_c   = HRESP_OKAY;
    cmd_wen_c = 1'b0;
    wd_wen_c  = 1'b0;
    rd_ren_c  = 1'b0;
    case (state_q)
      ST_WR_DATA: begin
        hready_c  = !cmd_full && !wd_full;
        cmd_wen_c = hready_c;
        wd_wen_c  = hready_c;
      end
      ST_RD_CMD: begin
        hready_c  = 1'b0;
        cmd_wen_c = !cmd_full;
      end
      ST_RD_WAIT: begin
        hready_c = 1'b0;
        rd_ren_c = !rd_empty;
      end
      ST_ERR1: begin
        hready_c = 1'b0;
        hresp_c  = HRESP_ERROR;
      end
      ST_ERR2: hresp_c = HRESP_ERROR;
      default: ;
    endcase
  end

  // Transfer FSM with registered address phase and read data.
  always_ff @(posedge hclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      hrdata_q <= '0;
    end else begin
      if (sample_c) cmd_q <= {ahb.hwrite, ahb.hburst, ahb.hsize, ahb.haddr};
      if (rd_ren_c) hrdata_q <= rd_rdata[DATA_WIDTH-1:0];
      case (state_q)
        ST_RD_CMD:  if (!cmd_full) state_q <= ST_RD_WAIT;
        ST_RD_WAIT: if (!rd_empty) state_q <= rd_rdata[DATA_WIDTH] ? ST_ERR1 : ST_RD_DONE;
        ST_ERR1:    state_q <= ST_ERR2;
        default: begin
          // IDLE, RD_DONE, ERR2 and an unstalled WR_DATA accept a new address phase.
          if (hready_c) begin
            if (sample_c && active_c) begin
              if (!legal_c)        state_q <= ST_ERR1;
              else if (ahb.hwrite) state_q <= ST_WR_DATA;
              else                 state_q <= ST_RD_CMD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  ahb_burst_tracker u_burst (
    .hclk       (hclk),
    .resetn     (resetn),
    .track_i    (sample_c & active_c),
    .htrans_i   (ahb.htrans),
    .hburst_i   (ahb.hburst),
    .prot_err_o (prot_err)
  );

  assign ahb.hready_o = hready_c;
  assign ahb.hresp    = hresp_c;
  assign ahb.hrdata   = hrdata_q;
  assign cmd_wen      = cmd_wen_c;
  assign cmd_wdata    = cmd_q;
  assign wd_wen       = wd_wen_c;
  assign wd_wdata     = ahb.hwdata;
  assign rd_ren       = rd_ren_c;

endmodule

// File: doc/ahb_bridge_frontend.md
Name: ahb_bridge_frontend

Overview:
Parametrised AHB-Lite slave front end for the AHB-to-APB bridge. Decodes AHB transfers and pushes command entries and write data into external command/write-data FIFOs. Returns read data, including APB error status, from an external read-data FIFO. Adds three things the earlier front end lacks: address-range and size decode with two-cycle ERROR responses, hready_in qualification, and burst beat tracking with protocol-violation flagging.

Parameters:
DATA_WIDTH, 32, AHB/APB data width (32 or 64)
ADDR_WIDTH, 32, haddr width
BASE_ADDR, 32'h0000_0000, first byte address claimed by the bridge
ADDR_SPAN, 32'h0001_0000, bytes claimed; valid range is [BASE_ADDR, BASE_ADDR+ADDR_SPAN)

Ports:
hclk  in  1  AHB clock
resetn  in  1  reset: asynchronous, active-low
hsel  in  1  slave select
hready_in  in  1  bus HREADY (address phase qualifier)
htrans  in  2  IDLE/BUSY/NSEQ/SEQ
hwrite  in  1  1=write
haddr  in  ADDR_WIDTH  address
hburst  in  3  burst type
hsize  in  3  transfer size
hwdata  in  DATA_WIDTH  write data (data phase)
hready_o  out  1  HREADYOUT
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  DATA_WIDTH  read data
cmd_wen  out  1  command FIFO push
cmd_wdata  out  ADDR_WIDTH+7  {hwrite, hburst, hsize, haddr} of the accepted transfer
cmd_full  in  1  command FIFO full
wd_wen  out  1  write-data FIFO push
wd_wdata  out  DATA_WIDTH  write data
wd_full  in  1  write-data FIFO full
rd_ren  out  1  read-data FIFO pop
rd_rdata  in  DATA_WIDTH+1  {pslverr, prdata}
rd_empty  in  1  read-data FIFO empty
prot_err  out  1  sticky burst-protocol violation flag

Behaviour:
- Reset values: hready_o=1, hresp=0, hrdata=0, all wen/ren=0, prot_err=0, beat_cnt=0, state=IDLE. Reset mid-transfer aborts everything; pending beats are dropped.
- Sample point: the address phase is sampled only when hsel & hready_in & hready_o. The registered copy is {hwrite, hburst, hsize, haddr}.
- Transfer classes:
  - Active: htrans ∈ {NSEQ, SEQ}.
  - Legal: haddr in range, hsize ≤ log2(DATA_WIDTH/8), haddr aligned to hsize.
- States:
  - IDLE: hready_o=1, hresp=0.
  - WR_DATA (write data phase): hready_o = !cmd_full & !wd_full. While hready_o=1, cmd_wen=wd_wen=1 combinationally; cmd_wdata comes from the registered address, wd_wdata=hwdata. While hready_o=0, stay in WR_DATA (wait states).
  - RD_CMD: hready_o=0; cmd_wen = !cmd_full. After the push, go to RD_WAIT.
  - RD_WAIT: hready_o=0. On !rd_empty: rd_ren=1 for one cycle and hrdata <= rd_rdata[DATA_WIDTH-1:0]. Then go to RD_DONE if pslverr=0, else ERR1.
  - RD_DONE: hready_o=1, hresp=0, hrdata held.
  - ERR1: hready_o=0, hresp=1.
  - ERR2: hready_o=1, hresp=1.
- Next state from any sampling state (IDLE, WR_DATA with hready_o=1, RD_DONE, ERR2):
  - legal active write → WR_DATA
  - legal active read → RD_CMD
  - illegal active → ERR1 (no FIFO push)
  - IDLE/BUSY or not sampled → IDLE
- ERR1 → ERR2 unconditionally.
- Minimum latency: write 1 data-phase cycle (no wait states when FIFOs not full). Read = 1 (RD_CMD) + ≥1 (RD_WAIT) + RD_DONE, so ≥2 wait states.
- Burst tracking, at each sampled active transfer:
  - NSEQ loads beat_cnt = length−1, where length is 4/8/16 for INCR4/8/16 and WRAP4/8/16, and 0 for SINGLE/INCR.
  - SEQ with fixed length decrements beat_cnt.
  - SEQ after SINGLE, SEQ with beat_cnt=0 on a fixed burst, or NSEQ while beat_cnt≠0 sets prot_err. The transfer is still processed normally.
  - INCR (undefined length) accepts any number of SEQ beats.
  - BUSY leaves beat_cnt unchanged and gets an OKAY zero-wait response.
  - prot_err clears only on reset.
- An ERROR mid-burst does not cancel tracking. If the master continues, later beats are decoded individually.
- cmd_wen and rd_ren never assert while the corresponding full/empty input is high.

Decomposition:
- Shared package ahb_bridge_pkg: htrans encodings (IDLE=0, BUSY=1, NSEQ=2, SEQ=3), hburst encodings, the cmd entry layout and its width function, the hresp encodings, and a burst_len(hburst) function.
- One natural sub-module, ahb_burst_tracker: holds beat_cnt and generates prot_err.

Test Plan:
- Single write NSEQ haddr=0x10, hwdata=0xDEADBEEF, FIFOs empty → next cycle hready_o=1, cmd_wen=1, cmd_wdata addr 0x10, wd_wdata=0xDEADBEEF, hresp=0.
- Write with cmd_full=1 for 3 cycles → hready_o=0 for exactly 3 data-phase cycles, then one push, no duplicate push.
- Single read 0x20, rd_rdata={0,0x12345678} available 2 cycles after cmd push → rd_ren pulses once, RD_DONE hrdata=0x12345678, hresp=0.
- Read returning pslverr=1, and a write to haddr=BASE_ADDR+ADDR_SPAN → ERR1 (hready_o=0, hresp=1) then ERR2 (hready_o=1, hresp=1); the out-of-range write performs no cmd/wd push.
- INCR4 write, 4 beats with one BUSY inserted → 4 cmd+wd pushes, prot_err=0. A fifth SEQ sets prot_err=1 and still pushes.
- Assert resetn low during RD_WAIT → hready_o=1, hresp=0, no rd_ren; after release, state is IDLE.
